// File: rtl/vga_timing_pkg.sv
// Shared constants and helpers for the parametrised VGA timing generator.
// Defaults describe 640x480@60 with a 25 MHz pixel rate derived from 100 MHz.
package vga_timing_pkg;

    localparam int DEF_H_ACTIVE = 32'd640;
    localparam int DEF_H_FP     = 32'd16;
    localparam int DEF_H_SYNC   = 32'd96;
    localparam int DEF_H_BP     = 32'd48;
    localparam int DEF_V_ACTIVE = 32'd480;
    localparam int DEF_V_FP     = 32'd10;
    localparam int DEF_V_SYNC   = 32'd2;
    localparam int DEF_V_BP     = 32'd33;

    localparam int DEF_HS_START = DEF_H_ACTIVE + DEF_H_FP;
    localparam int DEF_HS_END   = DEF_HS_START + DEF_H_SYNC - 32'd1;
    localparam int DEF_VS_START = DEF_V_ACTIVE + DEF_V_FP;
    localparam int DEF_VS_END   = DEF_VS_START + DEF_V_SYNC - 32'd1;

    function automatic int h_total(input int active, input int fp, input int sync, input int bp);
        return active + fp + sync + bp;
    endfunction

    function automatic int v_total(input int active, input int fp, input int sync, input int bp);
        return active + fp + sync + bp;
    endfunction

    function automatic int sync_start(input int active, input int fp);
        return active + fp;
    endfunction

    function automatic int sync_end(input int active, input int fp, input int sync);
        return active + fp + sync - 32'd1;
    endfunction

endpackage

// File: rtl/vga_timing_gen_sync_delay_line.sv
// Clock-enabled shift register that delays a sync level by DEPTH pixel periods.
// DEPTH=0 is a plain wire so the sync stays aligned with video_on.
module sync_delay_line #(
    parameter int   DEPTH   = 32'd0,
    parameter logic RST_VAL = 1'b1
) (
    input  logic clk,
    input  logic rst,
    input  logic ce,
    input  logic din,
    output logic dout
);

    generate
        if (DEPTH == 0) begin : g_bypass
            logic unused_s;
            assign unused_s = ^{clk, rst, ce};
            assign dout     = din;
        end else begin : g_shift
            logic [DEPTH-1:0] stages_r;

            // Shift one stage per pixel tick; stages come out of reset at the idle level
            always_ff @(posedge clk or negedge rst) begin
                if (!rst) begin
                    stages_r <= {DEPTH{RST_VAL}};
                end else if (ce) begin
                    stages_r <= (stages_r << 1) | DEPTH'(din);
                end
            end

            assign dout = stages_r[DEPTH-1];
        end
    endgenerate

endmodule

// File: rtl/vga_timing_gen.sv
// Parametrised VGA timing generator running from the system clock with a pixel
// clock-enable; produces syncs, coordinates and line/frame markers.
module vga_timing_gen
    import vga_timing_pkg::*;
#(
    parameter int   H_ACTIVE    = DEF_H_ACTIVE,
    parameter int   H_FP        = DEF_H_FP,
    parameter int   H_SYNC      = DEF_H_SYNC,
    parameter int   H_BP        = DEF_H_BP,
    parameter int   V_ACTIVE    = DEF_V_ACTIVE,
    parameter int   V_FP        = DEF_V_FP,
    parameter int   V_SYNC      = DEF_V_SYNC,
    parameter int   V_BP        = DEF_V_BP,
    parameter logic HS_POL      = 1'b0,
    parameter logic VS_POL      = 1'b0,
    parameter int   PIX_DIV     = 32'd4,
    parameter int   SCALE_SHIFT = 32'd2,
    parameter int   SYNC_DELAY  = 32'd0,
    parameter int   CNT_W       = 32'd10
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    output logic             pix_ce,
    output logic             hsync,
    output logic             vsync,
    output logic             video_on,
    output logic [CNT_W-1:0] pixel_column,
    output logic [CNT_W-1:0] pixel_row,
    output logic [CNT_W-1:0] col_scaled,
    output logic [CNT_W-1:0] row_scaled,
    output logic             line_start,
    output logic             frame_start,
    output logic [7:0]       frame_count
);

    localparam int H_TOTAL = h_total(H_ACTIVE, H_FP, H_SYNC, H_BP);
    localparam int V_TOTAL = v_total(V_ACTIVE, V_FP, V_SYNC, V_BP);
    localparam int DIV_W   = (PIX_DIV > 1) ? $clog2(PIX_DIV) : 32'd1;

    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(PIX_DIV - 32'd1);
    localparam logic [DIV_W-1:0] DIV_ONE  = DIV_W'(32'd1);
    localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(32'd1);
    localparam logic [CNT_W-1:0] H_LAST   = CNT_W'(H_TOTAL - 32'd1);
    localparam logic [CNT_W-1:0] V_LAST   = CNT_W'(V_TOTAL - 32'd1);
    localparam logic [CNT_W-1:0] H_ACT    = CNT_W'(H_ACTIVE);
    localparam logic [CNT_W-1:0] V_ACT    = CNT_W'(V_ACTIVE);
    localparam logic [CNT_W-1:0] HS_START = CNT_W'(sync_start(H_ACTIVE, H_FP));
    localparam logic [CNT_W-1:0] HS_END   = CNT_W'(sync_end(H_ACTIVE, H_FP, H_SYNC));
    localparam logic [CNT_W-1:0] VS_START = CNT_W'(sync_start(V_ACTIVE, V_FP));
    localparam logic [CNT_W-1:0] VS_END   = CNT_W'(sync_end(V_ACTIVE, V_FP, V_SYNC));

    generate
        if (H_SYNC < 1 || V_SYNC < 1) begin : g_err_sync
            $error("vga_timing_gen: H_SYNC and V_SYNC must be at least 1");
        end
        if (H_TOTAL > (32'd1 << CNT_W) || V_TOTAL > (32'd1 << CNT_W)) begin : g_err_total
            $error("vga_timing_gen: line/frame totals exceed the CNT_W counter range");
        end
        if (PIX_DIV < 1) begin : g_err_div
            $error("vga_timing_gen: PIX_DIV must be at least 1");
        end
        if (SYNC_DELAY < 0 || SYNC_DELAY > 7) begin : g_err_delay
            $error("vga_timing_gen: SYNC_DELAY must be within 0..7");
        end
    endgenerate

    logic [DIV_W-1:0] div_r;
    logic [CNT_W-1:0] hcnt_r;
    logic [CNT_W-1:0] vcnt_r;
    logic             tick_s;
    logic             h_wrap_s;
    logic             v_wrap_s;
    logic             hs_raw_s;
    logic             vs_raw_s;
    logic             hs_dly_s;
    logic             vs_dly_s;

    logic             pix_ce_r;
    logic             hsync_r;
    logic             vsync_r;
    logic             video_on_r;
    logic [CNT_W-1:0] pixel_column_r;
    logic [CNT_W-1:0] pixel_row_r;
    logic             line_start_r;
    logic             frame_start_r;
    logic [7:0]       frame_count_r;

    // With PIX_DIV=1 div_r never leaves zero, so the tick simply follows en
    assign tick_s   = en && (div_r == DIV_LAST);
    assign h_wrap_s = (hcnt_r == H_LAST);
    assign v_wrap_s = (vcnt_r == V_LAST);

    // Pixel divider: free-runs while enabled, holds its phase while paused
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            div_r <= {DIV_W{1'b0}};
        end else if (tick_s) begin
            div_r <= {DIV_W{1'b0}};
        end else if (en) begin
            div_r <= div_r + DIV_ONE;
        end
    end

    // Raster position counters, advanced once per pixel tick
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            hcnt_r <= CNT_ZERO;
            vcnt_r <= CNT_ZERO;
        end else if (tick_s) begin
            if (h_wrap_s) begin
                hcnt_r <= CNT_ZERO;
                vcnt_r <= v_wrap_s ? CNT_ZERO : (vcnt_r + CNT_ONE);
            end else begin
                hcnt_r <= hcnt_r + CNT_ONE;
            end
        end
    end

    // Undelayed sync levels decoded from the current raster position
    always_comb begin
        hs_raw_s = ~HS_POL;
        vs_raw_s = ~VS_POL;
        if ((hcnt_r >= HS_START) && (hcnt_r <= HS_END)) begin
            hs_raw_s = HS_POL;
        end else begin
            hs_raw_s = ~HS_POL;
        end
        if ((vcnt_r >= VS_START) && (vcnt_r <= VS_END)) begin
            vs_raw_s = VS_POL;
        end else begin
            vs_raw_s = ~VS_POL;
        end
    end

    sync_delay_line #(.DEPTH(SYNC_DELAY), .RST_VAL(~HS_POL)) u_hs_delay (
        .clk  (clk),
        .rst  (rst),
        .ce   (tick_s),
        .din  (hs_raw_s),
        .dout (hs_dly_s)
    );

    sync_delay_line #(.DEPTH(SYNC_DELAY), .RST_VAL(~VS_POL)) u_vs_delay (
        .clk  (clk),
        .rst  (rst),
        .ce   (tick_s),
        .din  (vs_raw_s),
        .dout (vs_dly_s)
    );

    // Output stage: loads the pre-increment position on each tick; markers are one-clk strobes
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pix_ce_r       <= 1'b0;
            line_start_r   <= 1'b0;
            frame_start_r  <= 1'b0;
            video_on_r     <= 1'b0;
            hsync_r        <= ~HS_POL;
            vsync_r        <= ~VS_POL;
            pixel_column_r <= CNT_ZERO;
            pixel_row_r    <= CNT_ZERO;
            frame_count_r  <= 8'd0;
        end else begin
            pix_ce_r      <= tick_s;
            line_start_r  <= tick_s && (hcnt_r == CNT_ZERO);
            frame_start_r <= tick_s && (hcnt_r == CNT_ZERO) && (vcnt_r == CNT_ZERO);
            if (tick_s) begin
                pixel_column_r <= hcnt_r;
                pixel_row_r    <= vcnt_r;
                video_on_r     <= (hcnt_r < H_ACT) && (vcnt_r < V_ACT);
                hsync_r        <= hs_dly_s;
                vsync_r        <= vs_dly_s;
                if (h_wrap_s && v_wrap_s) begin
                    frame_count_r <= frame_count_r + 8'd1;
                end
            end else if (!en) begin
                video_on_r <= 1'b0;
            end
        end
    end

    assign pix_ce       = pix_ce_r;
    assign hsync        = hsync_r;
    assign vsync        = vsync_r;
    assign video_on     = video_on_r;
    assign pixel_column = pixel_column_r;
    assign pixel_row    = pixel_row_r;
    assign col_scaled   = pixel_column_r >> SCALE_SHIFT;
    assign row_scaled   = pixel_row_r >> SCALE_SHIFT;
    assign line_start   = line_start_r;
    assign frame_start  = frame_start_r;
    assign frame_count  = frame_count_r;

endmodule

// File: tb/tb_vga_timing_gen.sv
// Scoreboard bench for vga_timing_gen: three instances (defaults, a tiny raster
// for frame/wrap behaviour, and a delayed/positive-hsync PIX_DIV=1 variant).
module tb_vga_timing_gen;

    typedef struct {
        int ha, hfp, hs, hbp, va, vfp, vs, vbp;
        bit hp, vp;
        int div, dly, sh;
    } cfg_t;

    typedef struct {
        int col, row, cs, rs, fc;
        bit von, hs, vs, ls, fs;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst_v [3];
    logic       en_v  [3];
    logic       pce   [3];
    logic       hs_o  [3];
    logic       vs_o  [3];
    logic       von   [3];
    logic [9:0] col   [3];
    logic [9:0] row   [3];
    logic [9:0] cs    [3];
    logic [9:0] rs    [3];
    logic       ls    [3];
    logic       fs    [3];
    logic [7:0] fc    [3];

    int   checks = 0;
    int   errors = 0;
    int   model_k [3];
    exp_t sb_q [$];

    always #5 clk = ~clk;

    vga_timing_gen u_dflt (
        .clk(clk), .rst(rst_v[0]), .en(en_v[0]), .pix_ce(pce[0]), .hsync(hs_o[0]),
        .vsync(vs_o[0]), .video_on(von[0]), .pixel_column(col[0]), .pixel_row(row[0]),
        .col_scaled(cs[0]), .row_scaled(rs[0]), .line_start(ls[0]),
        .frame_start(fs[0]), .frame_count(fc[0])
    );

    vga_timing_gen #(
        .H_ACTIVE(6), .H_FP(1), .H_SYNC(2), .H_BP(1),
        .V_ACTIVE(4), .V_FP(1), .V_SYNC(1), .V_BP(1),
        .PIX_DIV(1), .SCALE_SHIFT(1)
    ) u_small (
        .clk(clk), .rst(rst_v[1]), .en(en_v[1]), .pix_ce(pce[1]), .hsync(hs_o[1]),
        .vsync(vs_o[1]), .video_on(von[1]), .pixel_column(col[1]), .pixel_row(row[1]),
        .col_scaled(cs[1]), .row_scaled(rs[1]), .line_start(ls[1]),
        .frame_start(fs[1]), .frame_count(fc[1])
    );

    vga_timing_gen #(
        .HS_POL(1'b1), .PIX_DIV(1), .SYNC_DELAY(2)
    ) u_dly (
        .clk(clk), .rst(rst_v[2]), .en(en_v[2]), .pix_ce(pce[2]), .hsync(hs_o[2]),
        .vsync(vs_o[2]), .video_on(von[2]), .pixel_column(col[2]), .pixel_row(row[2]),
        .col_scaled(cs[2]), .row_scaled(rs[2]), .line_start(ls[2]),
        .frame_start(fs[2]), .frame_count(fc[2])
    );

    function automatic cfg_t cfg_of(input int sel);
        cfg_t c;
        c = '{ha:640, hfp:16, hs:96, hbp:48, va:480, vfp:10, vs:2, vbp:33,
              hp:1'b0, vp:1'b0, div:4, dly:0, sh:2};
        case (sel)
            1: c = '{ha:6, hfp:1, hs:2, hbp:1, va:4, vfp:1, vs:1, vbp:1,
                     hp:1'b0, vp:1'b0, div:1, dly:0, sh:1};
            2: begin
                c.hp  = 1'b1;
                c.div = 1;
                c.dly = 2;
            end
            default: ;
        endcase
        return c;
    endfunction

    // Expected outputs for the k-th pixel tick since reset release
    function automatic exp_t expect_at(input cfg_t c, input int k);
        exp_t e;
        int ht, vt, ft, pos, kd, hc, vr;
        ht    = c.ha + c.hfp + c.hs + c.hbp;
        vt    = c.va + c.vfp + c.vs + c.vbp;
        ft    = ht * vt;
        pos   = k % ft;
        e.col = pos % ht;
        e.row = pos / ht;
        e.cs  = e.col >> c.sh;
        e.rs  = e.row >> c.sh;
        e.von = (e.col < c.ha) && (e.row < c.va);
        e.ls  = (e.col == 0);
        e.fs  = (pos == 0);
        e.fc  = ((k + 1) / ft) % 256;
        kd    = k - c.dly;
        if (kd < 0) begin
            e.hs = ~c.hp;
            e.vs = ~c.vp;
        end else begin
            hc   = (kd % ft) % ht;
            vr   = (kd % ft) / ht;
            e.hs = (hc >= c.ha + c.hfp && hc < c.ha + c.hfp + c.hs) ? c.hp : ~c.hp;
            e.vs = (vr >= c.va + c.vfp && vr < c.va + c.vfp + c.vs) ? c.vp : ~c.vp;
        end
        return e;
    endfunction

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0d exp=%0d t=%0t", tag, got, exp, $time);
        end
    endtask

    task automatic check_reset(input int sel);
        cfg_t c;
        bit   h_idle, v_idle;
        c      = cfg_of(sel);
        h_idle = ~c.hp;
        v_idle = ~c.vp;
        check_val("rst_pix_ce", pce[sel], 0);
        check_val("rst_col", col[sel], 0);
        check_val("rst_row", row[sel], 0);
        check_val("rst_video_on", von[sel], 0);
        check_val("rst_line_start", ls[sel], 0);
        check_val("rst_frame_start", fs[sel], 0);
        check_val("rst_frame_count", fc[sel], 0);
        check_val("rst_hsync", hs_o[sel], h_idle);
        check_val("rst_vsync", vs_o[sel], v_idle);
    endtask

    task automatic wait_ce(input int sel, output int gap);
        gap = 0;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            gap++;
            if (pce[sel] === 1'b1) break;
        end
        if (pce[sel] !== 1'b1) check_val("pix_ce_timeout", 0, 1);
    endtask

    task automatic run_pix(input int sel, input int n, input bit chk);
        cfg_t c;
        exp_t e;
        int   gap;
        c = cfg_of(sel);
        for (int i = 0; i < n; i++) begin
            if (chk) sb_q.push_back(expect_at(c, model_k[sel]));
            model_k[sel]++;
            wait_ce(sel, gap);
            if (chk) begin
                e = sb_q.pop_front();
                check_val("ce_gap", gap, c.div);
                check_val("col", col[sel], e.col);
                check_val("row", row[sel], e.row);
                check_val("col_scaled", cs[sel], e.cs);
                check_val("row_scaled", rs[sel], e.rs);
                check_val("video_on", von[sel], e.von);
                check_val("hsync", hs_o[sel], e.hs);
                check_val("vsync", vs_o[sel], e.vs);
                check_val("line_start", ls[sel], e.ls);
                check_val("frame_start", fs[sel], e.fs);
                check_val("frame_count", fc[sel], e.fc);
            end
        end
    endtask

    initial begin
        for (int i = 0; i < 3; i++) begin
            rst_v[i]   = 1'b0;
            en_v[i]    = 1'b0;
            model_k[i] = 0;
        end
        repeat (5) @(negedge clk);
        for (int i = 0; i < 3; i++) check_reset(i);

        // Defaults: reset release with en, first-tick latency and one full line
        rst_v[0] = 1'b1;
        en_v[0]  = 1'b1;
        run_pix(0, 801, 1'b1);

        // Delayed positive hsync at PIX_DIV=1, then pause at col 300 row 10
        @(negedge clk);
        rst_v[2] = 1'b1;
        en_v[2]  = 1'b1;
        run_pix(2, 8301, 1'b1);
        en_v[2] = 1'b0;
        for (int i = 0; i < 37; i++) begin
            @(negedge clk);
            check_val("pause_pix_ce", pce[2], 0);
            check_val("pause_col", col[2], 300);
            check_val("pause_row", row[2], 10);
            check_val("pause_video_on", von[2], 0);
        end
        en_v[2] = 1'b1;
        run_pix(2, 5, 1'b1);

        // Tiny raster: two checked frames, fast-forward, then the 255->0 wrap
        @(negedge clk);
        rst_v[1] = 1'b1;
        en_v[1]  = 1'b1;
        run_pix(1, 140, 1'b1);
        run_pix(1, 255 * 70 + 60 - 140, 1'b0);
        run_pix(1, 35, 1'b1);

        // Mid-frame asynchronous reset, then restart from (0,0)
        rst_v[1] = 1'b0;
        #1;
        check_reset(1);
        @(negedge clk);
        check_reset(1);
        rst_v[1]   = 1'b1;
        model_k[1] = 0;
        run_pix(1, 75, 1'b1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
